wishbone_mux_n: RTL

- Registered Wishbone-classic 1-to-N address-decoding interconnect: one upstream master port, NUM_SLAVES downstream slave ports.
- Generalised successor of the fixed 3-slave mux: parametrised slave count and per-slave base/size.
- Adds registered request/response, error reporting for unmapped addresses, master-abort handling and an optional stall timeout.
- Sits between the caravel wishbone port or the jedro_1 data-side bridge and memory/peripheral slaves.

---
 rtl/wishbone_mux_n.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/wishbone_mux_n.sv
// wishbone_mux_n: registered Wishbone-classic 1-to-N address-decoding interconnect.
// Latency: slave strobe 1 cycle after request; master ack 1 cycle after slave ack; unmapped err after 1 cycle.
// Stall: waits for slave ack or master abort; define WB_MUX_N_TIMEOUT_EN for an error after TIMEOUT_CYCLES.
module wishbone_mux_n #(
  parameter int unsigned                NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*8-1:0]    SLAVE_AW       = {NUM_SLAVES{8'd2}},
  parameter int unsigned                TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  output logic [31:0]                wbs_dat_o,
  output logic [NUM_SLAVES-1:0]      wbm_cyc_o,
  output logic [NUM_SLAVES-1:0]      wbm_stb_o,
  output logic                       wbm_we_o,
  output logic [3:0]                 wbm_sel_o,
  output logic [31:0]                wbm_adr_o,
  output logic [31:0]                wbm_dat_o,
  input  logic [NUM_SLAVES-1:0]      wbm_ack_i,
  input  logic [NUM_SLAVES*32-1:0]   wbm_dat_i
);

  localparam int unsigned IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERR} state_t;

  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  logic [NUM_SLAVES-1:0]  cyc_q;
  logic [NUM_SLAVES-1:0]  stb_q;
  logic                   we_q;
  logic [3:0]             sel_q;
  logic [31:0]            adr_q;
  logic [31:0]            dat_q;
  logic [31:0]            rdat_q;
  logic                   ack_q;
  logic                   err_q;

  logic                   hit_d;
  logic [IW-1:0]          idx_d;
  logic                   sel_ack;
  logic [31:0]            sel_rdat;
  logic                   tmo_hit;

  // Upper address bits that must equal the base for a slave window of 2^aw bytes
  function automatic logic [31:0] aw_mask(input logic [7:0] aw);
    return 32'hFFFF_FFFF << aw;
  endfunction

  // Address decode; scanning downward lets the lowest matching index win on overlap
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (((wbs_adr_i ^ SLAVE_BASE[i*32 +: 32]) & aw_mask(SLAVE_AW[i*8 +: 8])) == 32'h0) begin
        hit_d = 1'b1;
        idx_d = IW'(i);
      end
    end
  end

  assign sel_ack  = wbm_ack_i[idx_q];
  assign sel_rdat = wbm_dat_i[32'(idx_q) * 32 +: 32];

`ifdef WB_MUX_N_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  assign tmo_hit = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic [7:0] tmo_unused;
  assign tmo_unused = 8'(TIMEOUT_CYCLES - 1);
  assign tmo_hit    = 1'b0;
`endif

  // Transfer FSM: all bus outputs are registered here
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cyc_q     <= '0;
      stb_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef WB_MUX_N_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            adr_q <= wbs_adr_i;
            dat_q <= wbs_dat_i;
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            idx_q <= idx_d;
            if (hit_d) begin
              cyc_q     <= ONE << idx_d;
              stb_q     <= ONE << idx_d;
              state_q   <= ACTIVE;
`ifdef WB_MUX_N_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end else begin
              // Unmapped: report error next cycle, nothing is strobed
              err_q   <= 1'b1;
              rdat_q  <= '0;
              state_q <= ERR;
            end
          end
        end
        ACTIVE: begin
          if (!wbs_cyc_i) begin
            // Master abort takes priority; a same-cycle slave ack is dropped
            cyc_q   <= '0;
            stb_q   <= '0;
            state_q <= IDLE;
          end else if (sel_ack) begin
            rdat_q  <= sel_rdat;
            ack_q   <= 1'b1;
            cyc_q   <= '0;
            stb_q   <= '0;
            state_q <= RESP;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            rdat_q  <= '0;
            cyc_q   <= '0;
            stb_q   <= '0;
            state_q <= ERR;
          end else begin
`ifdef WB_MUX_N_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        ERR: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = rdat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule
